riscv_decode_queue: RTL and testbench

Parametrised decode stage between fetch and issue. Each fetched word is decoded on entry by `riscv_decoder`. The word, its PC, its fault bits and its decode class flags go into a DEPTH-entry elastic queue. Issue therefore sees fully registered outputs, and fetch is decoupled from issue stalls by up to DEPTH instructions. Squash flushes the whole queue in one cycle.

---
 rtl/riscv_decode_queue_pkg.sv | 47 ++++
 rtl/riscv_decode_queue_decoder.sv | 105 ++++++++++
 rtl/riscv_decode_queue.sv | 135 +++++++++++++
 tb/tb_riscv_decode_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_decode_queue_pkg.sv
// Shared types for the decode queue: entry layout, decode flag positions
// and the RV32 opcode constants used by the enqueue-side decoder.
package riscv_decode_queue_pkg;

  localparam int XLEN           = 32;
  localparam int DECODE_FLAGS_W = 8;

  // Flag bit positions inside decode_flags_t (exec is the MSB).
  localparam int FLAG_EXEC     = 7;
  localparam int FLAG_LSU      = 6;
  localparam int FLAG_BRANCH   = 5;
  localparam int FLAG_MUL      = 4;
  localparam int FLAG_DIV      = 3;
  localparam int FLAG_CSR      = 2;
  localparam int FLAG_RD_VALID = 1;
  localparam int FLAG_INVALID  = 0;

  typedef logic [DECODE_FLAGS_W-1:0] decode_flags_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault_page;
    logic            fault_fetch;
    decode_flags_t   flags;
  } dq_entry_t;

  localparam int ENTRY_W = $bits(dq_entry_t);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
  localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

endpackage

// File: rtl/riscv_decode_queue_decoder.sv
// riscv_decoder: RV32I(+M) class decoder. A faulted fetch decodes as a CSR
// (exception) op only; an unrecognised word raises invalid and nothing else.
module riscv_decoder
  import riscv_decode_queue_pkg::*;
(
  input  logic        valid_i,
  input  logic        fetch_fault_i,
  input  logic        enable_muldiv_i,
  input  logic [31:0] opcode_i,
  output logic        exec_o,
  output logic        lsu_o,
  output logic        branch_o,
  output logic        mul_o,
  output logic        div_o,
  output logic        csr_o,
  output logic        rd_valid_o,
  output logic        invalid_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic legal, is_exec, is_lsu, is_branch, is_mul, is_div, is_csr, writes_rd;

  assign op = opcode_i[6:0];
  assign f3 = opcode_i[14:12];
  assign f7 = opcode_i[31:25];

  always_comb begin
    legal     = 1'b0;
    is_exec   = 1'b0;
    is_lsu    = 1'b0;
    is_branch = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_csr    = 1'b0;
    writes_rd = 1'b0;
    case (op)
      OPC_LUI, OPC_AUIPC: begin
        legal = 1'b1; is_exec = 1'b1; writes_rd = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; is_branch = 1'b1; writes_rd = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); is_branch = 1'b1; writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011); is_branch = 1'b1;
      end
      OPC_LOAD: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        is_lsu = 1'b1; writes_rd = 1'b1;
      end
      OPC_STORE: begin
        legal = (f3 <= 3'b010); is_lsu = 1'b1;
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
        is_exec = 1'b1; writes_rd = 1'b1;
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        if (f7 == 7'b0000000) begin
          legal = 1'b1; is_exec = 1'b1;
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101); is_exec = 1'b1;
        end else if (f7 == 7'b0000001) begin
          // M extension: funct3 0-3 are multiplies, 4-7 divides/remainders.
          legal = enable_muldiv_i; is_mul = !f3[2]; is_div = f3[2];
        end
      end
      OPC_MISC_MEM: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001); is_exec = 1'b1;
      end
      OPC_SYSTEM: begin
        is_csr = 1'b1;
        if (f3 == 3'b000) begin
          legal = opcode_i inside {INSTR_ECALL, INSTR_EBREAK, INSTR_MRET, INSTR_WFI};
        end else begin
          legal = (f3 != 3'b100); writes_rd = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    exec_o = 1'b0; lsu_o = 1'b0; branch_o = 1'b0; mul_o = 1'b0;
    div_o = 1'b0; csr_o = 1'b0; rd_valid_o = 1'b0; invalid_o = 1'b0;
    if (valid_i) begin
      if (fetch_fault_i) begin
        csr_o = 1'b1;
      end else if (!legal) begin
        invalid_o = 1'b1;
      end else begin
        exec_o = is_exec; lsu_o = is_lsu; branch_o = is_branch; mul_o = is_mul;
        div_o = is_div; csr_o = is_csr; rd_valid_o = writes_rd;
      end
    end
  end

endmodule

// File: rtl/riscv_decode_queue.sv
// Decode stage: decodes each fetched word on entry and buffers word, PC,
// fault bits and class flags in a DEPTH-entry circular queue towards issue.
module riscv_decode_queue
  import riscv_decode_queue_pkg::*;
#(
  parameter int SUPPORT_MULDIV = 1,
  parameter int DEPTH          = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       fetch_in_valid_i,
  input  logic [31:0]                fetch_in_instr_i,
  input  logic [31:0]                fetch_in_pc_i,
  input  logic                       fetch_in_fault_fetch_i,
  input  logic                       fetch_in_fault_page_i,
  output logic                       fetch_in_accept_o,
  input  logic                       squash_decode_i,
  input  logic                       fetch_out_accept_i,
  output logic                       fetch_out_valid_o,
  output logic [31:0]                fetch_out_instr_o,
  output logic [31:0]                fetch_out_pc_o,
  output logic                       fetch_out_fault_fetch_o,
  output logic                       fetch_out_fault_page_o,
  output logic                       fetch_out_instr_exec_o,
  output logic                       fetch_out_instr_lsu_o,
  output logic                       fetch_out_instr_branch_o,
  output logic                       fetch_out_instr_mul_o,
  output logic                       fetch_out_instr_div_o,
  output logic                       fetch_out_instr_csr_o,
  output logic                       fetch_out_instr_rd_valid_o,
  output logic                       fetch_out_instr_invalid_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic ENABLE_MULDIV = (SUPPORT_MULDIV != 0);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  dq_entry_t        mem_q [DEPTH];
  dq_entry_t        entry_w, head_w;
  decode_flags_t    dec_flags;
  logic             any_fault_w, push_w, pop_w;
  logic [31:0]      stored_instr_w;

  // Handshake: a transfer happens on an edge where valid and accept are both
  // high and squash is low; accept/valid come from the registered count only.
  assign fetch_in_accept_o = (count_q != FULL_COUNT);
  assign fetch_out_valid_o = (count_q != '0);
  assign push_w = fetch_in_valid_i && fetch_in_accept_o && !squash_decode_i;
  assign pop_w  = fetch_out_valid_o && fetch_out_accept_i && !squash_decode_i;

  assign any_fault_w    = fetch_in_fault_fetch_i | fetch_in_fault_page_i;
  assign stored_instr_w = any_fault_w ? 32'h0 : fetch_in_instr_i;

  riscv_decoder u_decoder (
    .valid_i         (fetch_in_valid_i),
    .fetch_fault_i   (any_fault_w),
    .enable_muldiv_i (ENABLE_MULDIV),
    .opcode_i        (stored_instr_w),
    .exec_o          (dec_flags[FLAG_EXEC]),
    .lsu_o           (dec_flags[FLAG_LSU]),
    .branch_o        (dec_flags[FLAG_BRANCH]),
    .mul_o           (dec_flags[FLAG_MUL]),
    .div_o           (dec_flags[FLAG_DIV]),
    .csr_o           (dec_flags[FLAG_CSR]),
    .rd_valid_o      (dec_flags[FLAG_RD_VALID]),
    .invalid_o       (dec_flags[FLAG_INVALID])
  );

  always_comb begin
    entry_w             = '0;
    entry_w.pc          = fetch_in_pc_i;
    entry_w.instr       = stored_instr_w;
    entry_w.fault_page  = fetch_in_fault_page_i;
    entry_w.fault_fetch = fetch_in_fault_fetch_i;
    entry_w.flags       = dec_flags;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (squash_decode_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push_w) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; the count gates its use.
  always_ff @(posedge clk_i) begin
    if (push_w) mem_q[wr_ptr_q] <= entry_w;
  end

  assign head_w = fetch_out_valid_o ? mem_q[rd_ptr_q] : '0;

  assign fetch_out_pc_o             = head_w.pc;
  assign fetch_out_instr_o          = head_w.instr;
  assign fetch_out_fault_page_o     = head_w.fault_page;
  assign fetch_out_fault_fetch_o    = head_w.fault_fetch;
  assign fetch_out_instr_exec_o     = head_w.flags[FLAG_EXEC];
  assign fetch_out_instr_lsu_o      = head_w.flags[FLAG_LSU];
  assign fetch_out_instr_branch_o   = head_w.flags[FLAG_BRANCH];
  assign fetch_out_instr_mul_o      = head_w.flags[FLAG_MUL];
  assign fetch_out_instr_div_o      = head_w.flags[FLAG_DIV];
  assign fetch_out_instr_csr_o      = head_w.flags[FLAG_CSR];
  assign fetch_out_instr_rd_valid_o = head_w.flags[FLAG_RD_VALID];
  assign fetch_out_instr_invalid_o  = head_w.flags[FLAG_INVALID];
  assign level_o                    = count_q;

endmodule

// File: tb/tb_riscv_decode_queue.sv
// Bench for riscv_decode_queue: DUT A (DEPTH=4, mul/div on) is scoreboarded;
// DUT B (DEPTH=2, mul/div off) checks decode gating and the small-depth case.
module tb_riscv_decode_queue;

  localparam int W = 74;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic        a_in_valid = 0, a_fp = 0, a_ff = 0, a_squash = 0, a_out_accept = 0;
  logic [31:0] a_in_instr = 0, a_in_pc = 0;
  logic        a_in_accept, a_out_valid, a_out_fp, a_out_ff;
  logic [31:0] a_out_instr, a_out_pc;
  logic        a_exec, a_lsu, a_branch, a_mul, a_div, a_csr, a_rdv, a_inv;
  logic [2:0]  a_level;

  riscv_decode_queue #(.SUPPORT_MULDIV(1), .DEPTH(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_in_valid_i(a_in_valid), .fetch_in_instr_i(a_in_instr), .fetch_in_pc_i(a_in_pc),
    .fetch_in_fault_fetch_i(a_ff), .fetch_in_fault_page_i(a_fp), .fetch_in_accept_o(a_in_accept),
    .squash_decode_i(a_squash), .fetch_out_accept_i(a_out_accept), .fetch_out_valid_o(a_out_valid),
    .fetch_out_instr_o(a_out_instr), .fetch_out_pc_o(a_out_pc),
    .fetch_out_fault_fetch_o(a_out_ff), .fetch_out_fault_page_o(a_out_fp),
    .fetch_out_instr_exec_o(a_exec), .fetch_out_instr_lsu_o(a_lsu),
    .fetch_out_instr_branch_o(a_branch), .fetch_out_instr_mul_o(a_mul),
    .fetch_out_instr_div_o(a_div), .fetch_out_instr_csr_o(a_csr),
    .fetch_out_instr_rd_valid_o(a_rdv), .fetch_out_instr_invalid_o(a_inv),
    .level_o(a_level)
  );

  // ---------------- DUT B ----------------
  logic        b_in_valid = 0, b_squash = 0, b_out_accept = 0, b_fp = 0, b_ff = 0;
  logic [31:0] b_in_instr = 0, b_in_pc = 0;
  logic        b_in_accept, b_out_valid, b_out_fp, b_out_ff;
  logic [31:0] b_out_instr, b_out_pc;
  logic        b_exec, b_lsu, b_branch, b_mul, b_div, b_csr, b_rdv, b_inv;
  logic [1:0]  b_level;

  riscv_decode_queue #(.SUPPORT_MULDIV(0), .DEPTH(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_in_valid_i(b_in_valid), .fetch_in_instr_i(b_in_instr), .fetch_in_pc_i(b_in_pc),
    .fetch_in_fault_fetch_i(b_ff), .fetch_in_fault_page_i(b_fp), .fetch_in_accept_o(b_in_accept),
    .squash_decode_i(b_squash), .fetch_out_accept_i(b_out_accept), .fetch_out_valid_o(b_out_valid),
    .fetch_out_instr_o(b_out_instr), .fetch_out_pc_o(b_out_pc),
    .fetch_out_fault_fetch_o(b_out_ff), .fetch_out_fault_page_o(b_out_fp),
    .fetch_out_instr_exec_o(b_exec), .fetch_out_instr_lsu_o(b_lsu),
    .fetch_out_instr_branch_o(b_branch), .fetch_out_instr_mul_o(b_mul),
    .fetch_out_instr_div_o(b_div), .fetch_out_instr_csr_o(b_csr),
    .fetch_out_instr_rd_valid_o(b_rdv), .fetch_out_instr_invalid_o(b_inv),
    .level_o(b_level)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] drv_exp = '0;
  logic [W-1:0] a_head;

  // Flags order: exec lsu branch mul div csr rd_valid invalid.
  logic [31:0] tbl_instr [13];
  logic [7:0]  tbl_flags [13];
  localparam logic [7:0] F_FAULT = 8'b0000_0100;

  assign a_head = {a_out_pc, a_out_instr, a_out_fp, a_out_ff,
                   a_exec, a_lsu, a_branch, a_mul, a_div, a_csr, a_rdv, a_inv};

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: a transfer is judged mid-cycle, with inputs and outputs stable.
  always @(negedge clk) begin
    if (!rst_n || a_squash) begin
      exp_q.delete();
    end else begin
      if (a_out_valid && a_out_accept) begin
        check("sb_nonempty", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) check("pop_entry", a_head, exp_q.pop_front());
      end
      if (a_in_valid && a_in_accept) exp_q.push_back(drv_exp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                          input logic fp, input logic ff, input logic [7:0] flags);
    a_in_valid = v;
    a_in_instr = instr;
    a_in_pc    = pc;
    a_fp       = fp;
    a_ff       = ff;
    drv_exp    = {pc, (fp | ff) ? 32'h0 : instr, fp, ff, flags};
  endtask

  task automatic idle_in();
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic drain_a(input string tag);
    a_out_accept = 1'b1;
    for (int k = 0; k < 20 && a_out_valid; k++) tick();
    a_out_accept = 1'b0;
    check(tag, W'(a_out_valid), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  logic [31:0] pc_base;

  initial begin
    tbl_instr[0]  = 32'h0050_0093; tbl_flags[0]  = 8'b1000_0010; // addi
    tbl_instr[1]  = 32'h1234_5137; tbl_flags[1]  = 8'b1000_0010; // lui
    tbl_instr[2]  = 32'h0000_00EF; tbl_flags[2]  = 8'b0010_0010; // jal
    tbl_instr[3]  = 32'h0000_0063; tbl_flags[3]  = 8'b0010_0000; // beq
    tbl_instr[4]  = 32'h0001_2283; tbl_flags[4]  = 8'b0100_0010; // lw
    tbl_instr[5]  = 32'h0051_2023; tbl_flags[5]  = 8'b0100_0000; // sw
    tbl_instr[6]  = 32'h0020_81B3; tbl_flags[6]  = 8'b1000_0010; // add
    tbl_instr[7]  = 32'h4020_81B3; tbl_flags[7]  = 8'b1000_0010; // sub
    tbl_instr[8]  = 32'h0231_00B3; tbl_flags[8]  = 8'b0001_0010; // mul
    tbl_instr[9]  = 32'h0230_C0B3; tbl_flags[9]  = 8'b0000_1010; // div
    tbl_instr[10] = 32'h3001_10F3; tbl_flags[10] = 8'b0000_0110; // csrrw
    tbl_instr[11] = 32'h0000_0073; tbl_flags[11] = 8'b0000_0100; // ecall
    tbl_instr[12] = 32'hFFFF_FFFF; tbl_flags[12] = 8'b0000_0001; // illegal

    // Reset values
    repeat (3) tick();
    check("rst_valid", W'(a_out_valid), W'(0));
    check("rst_accept", W'(a_in_accept), W'(1));
    check("rst_level", W'(a_level), W'(0));
    check("rst_head", a_head, W'(0));
    rst_n = 1'b1;
    tick();

    // Single instruction: visible in the cycle after the push edge
    drive_in(1'b1, 32'h0050_0093, 32'h8000_0000, 1'b0, 1'b0, 8'b1000_0010);
    tick();
    idle_in();
    check("single_valid", W'(a_out_valid), W'(1));
    check("single_pc", W'(a_out_pc), W'(32'h8000_0000));
    check("single_exec_rdv_inv", W'({a_exec, a_rdv, a_inv}), W'(3'b110));
    check("single_level", W'(a_level), W'(1));
    a_out_accept = 1'b1;
    tick();
    a_out_accept = 1'b0;
    check("empty_valid", W'(a_out_valid), W'(0));
    check("empty_gated", a_head, W'(0));

    // Fill and back-pressure
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, tbl_instr[i], 32'h1000 + 32'(i * 4), 1'b0, 1'b0, tbl_flags[i]);
      tick();
    end
    drive_in(1'b1, tbl_instr[4], 32'h1010, 1'b0, 1'b0, tbl_flags[4]);
    check("full_accept", W'(a_in_accept), W'(0));
    check("full_level", W'(a_level), W'(4));
    tick();
    check("full_5th_dropped", W'(a_level), W'(4));
    a_out_accept = 1'b1;
    tick();
    check("pop_full_accept", W'(a_in_accept), W'(1));
    check("pop_full_level", W'(a_level), W'(3));
    tick();
    check("refill_level", W'(a_level), W'(3));
    idle_in();
    drain_a("fill_drained");

    // Streaming and wrap at 1 instruction/cycle
    pc_base = 32'($urandom_range(32'h0000_FFFF, 32'h0000_0100)) << 8;
    a_out_accept = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_in(1'b1, tbl_instr[i % 13], pc_base + 32'(i * 4), 1'b0, 1'b0, tbl_flags[i % 13]);
      tick();
      check("stream_level", W'(a_level), W'(1));
    end
    idle_in();
    tick();
    check("stream_empty", W'(a_level), W'(0));
    a_out_accept = 1'b0;

    // Illegal word without fault
    drive_in(1'b1, tbl_instr[12], 32'h2F00, 1'b0, 1'b0, tbl_flags[12]);
    tick();
    idle_in();
    check("illegal_inv", W'(a_inv), W'(1));
    drain_a("illegal_drained");

    // Faults: word zeroed, decoder sees a faulted input
    drive_in(1'b1, 32'hFFFF_FFFF, 32'h3000, 1'b1, 1'b0, F_FAULT);
    tick();
    drive_in(1'b1, 32'h0050_0093, 32'h3004, 1'b0, 1'b1, F_FAULT);
    tick();
    idle_in();
    check("fault_instr", W'(a_out_instr), W'(0));
    check("fault_bits", W'({a_out_fp, a_out_ff}), W'(2'b10));
    check("fault_flags", W'({a_exec, a_lsu, a_branch, a_mul, a_div, a_csr, a_rdv, a_inv}),
          W'(F_FAULT));
    drain_a("fault_drained");

    // Squash with a simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, tbl_instr[i], 32'h4000 + 32'(i * 4), 1'b0, 1'b0, tbl_flags[i]);
      tick();
    end
    drive_in(1'b1, tbl_instr[7], 32'h4FFC, 1'b0, 1'b0, tbl_flags[7]);
    check("presquash_level", W'(a_level), W'(3));
    a_out_accept = 1'b1;
    a_squash = 1'b1;
    tick();
    a_squash = 1'b0;
    a_out_accept = 1'b0;
    idle_in();
    check("squash_valid", W'(a_out_valid), W'(0));
    check("squash_level", W'(a_level), W'(0));
    check("squash_accept", W'(a_in_accept), W'(1));
    check("squash_head", a_head, W'(0));
    drive_in(1'b1, tbl_instr[6], 32'h5000, 1'b0, 1'b0, tbl_flags[6]);
    tick();
    idle_in();
    check("postsquash_level", W'(a_level), W'(1));
    drain_a("squash_drained");

    // Asynchronous reset mid-operation
    for (int i = 0; i < 2; i++) begin
      drive_in(1'b1, tbl_instr[4 + i], 32'h6000 + 32'(i * 4), 1'b0, 1'b0, tbl_flags[4 + i]);
      tick();
    end
    idle_in();
    check("prereset_level", W'(a_level), W'(2));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", W'(a_level), W'(0));
    check("async_rst_valid", W'(a_out_valid), W'(0));
    check("async_rst_accept", W'(a_in_accept), W'(1));
    tick();
    rst_n = 1'b1;
    drive_in(1'b1, tbl_instr[10], 32'h7000, 1'b0, 1'b0, tbl_flags[10]);
    tick();
    idle_in();
    drain_a("postreset_drained");

    // DUT B: mul/div disabled, DEPTH=2
    b_in_valid = 1'b1; b_in_instr = 32'h0231_00B3; b_in_pc = 32'h9000;
    tick();
    b_in_instr = 32'h0230_C0B3; b_in_pc = 32'h9004;
    check("b_mul_valid", W'(b_out_valid), W'(1));
    check("b_mul_flags", W'({b_exec, b_mul, b_div, b_rdv, b_inv}), W'(5'b00001));
    check("b_mul_pc", W'(b_out_pc), W'(32'h9000));
    tick();
    b_in_valid = 1'b0;
    check("b_full_accept", W'(b_in_accept), W'(0));
    check("b_full_level", W'(b_level), W'(2));
    b_out_accept = 1'b1;
    tick();
    b_out_accept = 1'b0;
    check("b_div_flags", W'({b_exec, b_mul, b_div, b_rdv, b_inv}), W'(5'b00001));
    check("b_div_pc", W'(b_out_pc), W'(32'h9004));
    check("b_reaccept", W'(b_in_accept), W'(1));

    check("sb_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
